fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, word-aligned fetch address after reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  decode stage cannot accept; inst held while high.
REQ-005 branch_taken  input  1  single-cycle redirect pulse from execute.
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored, treated as 00.
REQ-007 imem_ready  input  1  instruction memory response valid this cycle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; stable while imem_req=1 until imem_ready=1.
REQ-011 inst  output  32  instruction word to decoder.
REQ-012 inst_valid  output  1  inst holds a live instruction.
REQ-013 pc_out  output  32  address of the word on inst.

Function
REQ-014 State machine SHALL have states IDLE, FETCH, STALL, DRAIN.
REQ-015 Registers: pc (next fetch address), inst, pc_out, inst_valid, pend_inst, pend_pc, redirect_pc.
REQ-016 imem_req SHALL be 1 in FETCH and DRAIN, 0 in IDLE and STALL; imem_addr SHALL equal pc in FETCH and IDLE, and the drained address in DRAIN.
REQ-017 IDLE SHALL transition unconditionally to FETCH on the first clock after reset release.
REQ-018 Decode consumes inst on any cycle with inst_valid=1 and stall=0.
REQ-019 FETCH, imem_ready=1, (inst_valid=0 or stall=0), no branch: inst<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+4; stay FETCH.
REQ-020 FETCH, imem_ready=1, inst_valid=1, stall=1, no branch: pend_inst<=imem_rdata, pend_pc<=pc, pc<=pc+4; go STALL.
REQ-021 FETCH, imem_ready=0, inst_valid=1, stall=0: inst_valid<=0.
REQ-022 STALL with stall=0, no branch: inst<=pend_inst, pc_out<=pend_pc, inst_valid<=1; go FETCH.
REQ-023 STALL with stall=1: all registers hold.
REQ-024 branch_taken SHALL take priority over stall and imem_ready in every state.
REQ-025 Branch in FETCH with imem_ready=1: response discarded, pc<={branch_target[31:2],2'b00}, inst_valid<=0, inst<=32'h0000_0013; stay FETCH.
REQ-026 Branch in FETCH with imem_ready=0: redirect_pc<=aligned target, inst_valid<=0, inst<=32'h0000_0013; go DRAIN, holding imem_addr at the outstanding address.
REQ-027 DRAIN: imem_req=1 at old address; on imem_ready=1, response discarded, pc<=redirect_pc; go FETCH.
REQ-028 Branch in DRAIN SHALL overwrite redirect_pc; if imem_ready=1 same cycle, pc<=new target and go FETCH.
REQ-029 Branch in STALL: pending word discarded, inst_valid<=0, pc<=aligned target; go FETCH.
REQ-030 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-031 inst_valid SHALL never be 1 for a word fetched before a taken branch after the branch cycle.

Reset
REQ-032 While nrst=0: state=IDLE, pc=RESET_PC, inst=32'h0000_0013, pc_out=RESET_PC, inst_valid=0, imem_req=0, pend/redirect registers=0, imem_addr=RESET_PC.
REQ-033 nrst asserted mid-request SHALL abandon the request immediately; no response is captured after reset release until a new FETCH request.

Verification
REQ-034 Reset release, imem_ready=1 every cycle, words A,B,C -> inst A/pc_out 0, B/4, C/8 on consecutive cycles, inst_valid=1 from cycle 2.
REQ-035 stall=1 while inst=A and response B arrives -> STALL, imem_req=0, inst stays A; stall=0 -> inst=B, pc_out=4 next cycle.
REQ-036 branch_taken, target 32'h100, imem_ready=0 -> DRAIN, imem_addr unchanged; ready -> next imem_addr=32'h100, inst_valid=0 until 32'h100 word returns.
REQ-037 branch_taken with stall=1 in STALL, target 32'h203 -> next imem_addr=32'h200, pending word never appears on inst.
REQ-038 pc=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-039 nrst pulsed low during DRAIN -> outputs at REQ-032 values, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory-side and decode-side signals.
interface fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc_out;

  modport master (
    input  stall, branch_taken, branch_target, imem_ready, imem_rdata,
    output imem_req, imem_addr, inst, inst_valid, pc_out
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_ready, imem_rdata,
    input  imem_req, imem_addr, inst, inst_valid, pc_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request, a one-word skid slot for
// decode back-pressure, and branch redirect with draining of an in-flight word.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// FETCH | request outstanding at pc
// STALL | decode blocked and a second word is parked in pend_inst
// DRAIN | redirect pending; waiting to discard the in-flight response
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            nrst,
  fetch_unit_if.master    bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        inst_valid_q;
  logic [31:0] pend_inst;
  logic [31:0] pend_pc;
  logic [31:0] redirect_pc;
  logic [31:0] target_aligned;
  logic        req;

  assign target_aligned = {bus.branch_target[31:2], 2'b00};

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection; branch outranks stall and memory response
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (bus.branch_taken)
          state_nxt = bus.imem_ready ? FETCH : DRAIN;
        else if (bus.imem_ready && inst_valid_q && bus.stall)
          state_nxt = STALL;
      end
      STALL: begin
        if (bus.branch_taken || !bus.stall) state_nxt = FETCH;
      end
      DRAIN: begin
        if (bus.imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request outputs; pc is not advanced while draining, so it still
  // holds the outstanding address in DRAIN
  always_comb begin
    req = (state == FETCH) || (state == DRAIN);
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.pc_out     = pc_out_q;

  // Datapath registers: pc, decode word, skid slot and redirect target
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc           <= RESET_PC;
      inst_q       <= NOP;
      pc_out_q     <= RESET_PC;
      inst_valid_q <= 1'b0;
      pend_inst    <= 32'h0;
      pend_pc      <= 32'h0;
      redirect_pc  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.branch_taken) pc <= target_aligned;
        end
        FETCH: begin
          if (bus.branch_taken) begin
            inst_valid_q <= 1'b0;
            inst_q       <= NOP;
            if (bus.imem_ready) pc          <= target_aligned;
            else                redirect_pc <= target_aligned;
          end else if (bus.imem_ready) begin
            if (!inst_valid_q || !bus.stall) begin
              inst_q       <= bus.imem_rdata;
              pc_out_q     <= pc;
              inst_valid_q <= 1'b1;
            end else begin
              pend_inst <= bus.imem_rdata;
              pend_pc   <= pc;
            end
            pc <= pc + 32'd4;
          end else if (inst_valid_q && !bus.stall) begin
            inst_valid_q <= 1'b0;
          end
        end
        STALL: begin
          if (bus.branch_taken) begin
            inst_valid_q <= 1'b0;
            inst_q       <= NOP;
            pc           <= target_aligned;
          end else if (!bus.stall) begin
            inst_q       <= pend_inst;
            pc_out_q     <= pend_pc;
            inst_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.branch_taken) begin
            if (bus.imem_ready) pc          <= target_aligned;
            else                redirect_pc <= target_aligned;
          end else if (bus.imem_ready) begin
            pc <= redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a buffer-occupancy model of the fetch pipeline checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] KEY      = 32'hDEAD_0000;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: words delivered to decode sit in a queue (head is on inst, at most
  // two with one parked); a request is issued whenever the queue is not full.
  logic [31:0] q_w[$];
  logic [31:0] q_pc[$];
  logic        m_started = 1'b0;
  logic [31:0] m_addr    = RESET_PC;
  logic        m_drain   = 1'b0;
  logic [31:0] m_redir   = 32'h0;

  task automatic model_reset();
    q_w.delete();
    q_pc.delete();
    m_started = 1'b0;
    m_addr    = RESET_PC;
    m_drain   = 1'b0;
    m_redir   = 32'h0;
  endtask

  task automatic model_step();
    logic        req;
    logic [31:0] tgt;
    req = m_started && (q_w.size() < 2);
    tgt = bus.branch_target & ~32'h3;
    if (!m_started) begin
      m_started = 1'b1;
      if (bus.branch_taken) m_addr = tgt;
    end else if (bus.branch_taken) begin
      q_w.delete();
      q_pc.delete();
      if (req && !bus.imem_ready) begin
        m_drain = 1'b1;
        m_redir = tgt;
      end else begin
        m_drain = 1'b0;
        m_addr  = tgt;
      end
    end else begin
      if (q_w.size() > 0 && !bus.stall) begin
        void'(q_w.pop_front());
        void'(q_pc.pop_front());
      end
      if (req && bus.imem_ready) begin
        if (m_drain) begin
          m_drain = 1'b0;
          m_addr  = m_redir;
        end else begin
          q_w.push_back(bus.imem_rdata);
          q_pc.push_back(m_addr);
          m_addr = m_addr + 32'd4;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) model_reset();
      else       model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      check("req", {31'b0, bus.imem_req}, {31'b0, m_started && (q_w.size() < 2)});
      check("addr", bus.imem_addr, m_addr);
      check("valid", {31'b0, bus.inst_valid}, {31'b0, q_w.size() > 0});
      if (q_w.size() > 0) begin
        check("inst", bus.inst, q_w[0]);
        check("pc_out", bus.pc_out, q_pc[0]);
      end else if (!m_started) begin
        check("idle_inst", bus.inst, NOP);
        check("idle_pc_out", bus.pc_out, RESET_PC);
      end
    end
  endtask

  // One cycle of stimulus: drive, then advance to 1 time unit past the edge
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.imem_ready    = rdy;
    bus.imem_rdata    = bus.imem_addr ^ KEY;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    #2 nrst = 1'b0;
    #1;
    fork
      model_loop();
      compare_loop();
    join_none
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_inst", bus.inst, 32'h0000_0013);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    nrst = 1'b1;

    // streaming A, B, C
    cyc(0, 0, 0, 1);
    check("first_req", {31'b0, bus.imem_req}, 32'h1);
    cyc(0, 0, 0, 1);
    check("A", bus.inst, 32'hDEAD_0000); check("A_pc", bus.pc_out, 32'h0);
    cyc(0, 0, 0, 1);
    check("B", bus.inst, 32'hDEAD_0004); check("B_pc", bus.pc_out, 32'h4);
    cyc(0, 0, 0, 1);
    check("C", bus.inst, 32'hDEAD_0008); check("C_pc", bus.pc_out, 32'h8);

    // decode stall with a word arriving
    cyc(1, 0, 0, 1);
    check("stall_req", {31'b0, bus.imem_req}, 32'h0);
    check("stall_inst", bus.inst, 32'hDEAD_0008);
    cyc(1, 0, 0, 1);
    check("stall_hold", bus.inst, 32'hDEAD_0008);
    cyc(0, 0, 0, 0);
    check("unstall", bus.inst, 32'hDEAD_000C); check("unstall_pc", bus.pc_out, 32'hC);

    // branch with response outstanding -> drain
    cyc(0, 1, 32'h100, 0);
    check("drain_addr", bus.imem_addr, 32'h10);
    check("drain_valid", {31'b0, bus.inst_valid}, 32'h0);
    cyc(0, 0, 0, 0);
    check("drain_hold", bus.imem_addr, 32'h10);
    cyc(0, 0, 0, 1);
    check("redir_addr", bus.imem_addr, 32'h100);
    check("redir_valid", {31'b0, bus.inst_valid}, 32'h0);
    cyc(0, 0, 0, 1);
    check("tgt_word", bus.inst, 32'hDEAD_0100);

    // branch while parked in STALL, unaligned target
    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h203, 0);
    check("stall_br_addr", bus.imem_addr, 32'h200);
    check("stall_br_valid", {31'b0, bus.inst_valid}, 32'h0);
    cyc(0, 0, 0, 1);
    check("stall_br_word", bus.inst, 32'hDEAD_0200);
    check("stall_br_pc", bus.pc_out, 32'h200);

    // branch in FETCH with response present
    cyc(0, 1, 32'h3F0, 1);
    check("fetch_br_addr", bus.imem_addr, 32'h3F0);
    cyc(0, 0, 0, 1);

    // repeated branch while draining, then branch coincident with response
    cyc(0, 1, 32'h500, 0);
    cyc(0, 1, 32'h600, 0);
    cyc(0, 0, 0, 1);
    check("drain_rebr", bus.imem_addr, 32'h600);
    cyc(0, 1, 32'h700, 0);
    cyc(0, 1, 32'h800, 1);
    check("drain_br_rdy", bus.imem_addr, 32'h800);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    check("consume_empty", {31'b0, bus.inst_valid}, 32'h0);

    // address wrap
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 1);
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    check("wrap_inst", bus.inst, 32'h2152_FFFC);

    // reset during drain
    cyc(0, 1, 32'h900, 0);
    nrst = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("mid_rst_addr", bus.imem_addr, RESET_PC);
    check("mid_rst_inst", bus.inst, NOP);
    check("mid_rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    @(posedge clk); #1;
    nrst = 1'b1;
    cyc(0, 0, 0, 1);
    check("post_rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("post_rst_addr", bus.imem_addr, RESET_PC);
    cyc(0, 0, 0, 1);
    check("post_rst_word", bus.inst, 32'hDEAD_0000);

    // mixed traffic, checked by the model every cycle
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
          $urandom, $urandom_range(0, 2) != 0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
